// File: rtl/paddle_ctrl.sv
// Two-paddle horizontal position controller: keyboard or ball-tracking moves,
// paced by a pausable tick divider, with saturating edge limits.
module paddle_ctrl #(
  parameter int unsigned POS_W     = 8,
  parameter int unsigned FIELD_MAX = 239,
  parameter int unsigned PAD_LEN   = 40,
  parameter int unsigned PAD_INI   = 100,
  parameter int unsigned STEP      = 2,
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned DEADBAND  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pause,
  input  logic             key_ul,
  input  logic             key_ur,
  input  logic             key_dl,
  input  logic             key_dr,
  input  logic             mode_u,
  input  logic             mode_d,
  input  logic [POS_W-1:0] ball_x,
  output logic [POS_W-1:0] paddleU_ls,
  output logic [POS_W-1:0] paddleD_ls,
  output logic [POS_W-1:0] paddleU_pos,
  output logic [POS_W-1:0] paddleD_pos,
  output logic [1:0]       bound_u,
  output logic [1:0]       bound_d
);

  // Two extra bits keep centre+deadband and ls+STEP comparisons free of wrap.
  localparam int unsigned EXT_W   = POS_W + 2;
  localparam int unsigned LS_MAX  = FIELD_MAX + 1 - PAD_LEN;
  localparam int unsigned LS_RST  = (PAD_INI > LS_MAX) ? LS_MAX : PAD_INI;
  localparam int unsigned HALF_M1 = PAD_LEN / 2 - 1;
  localparam int unsigned CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_TOP = TICK_DIV - 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] u_ls_q, u_ls_d;
  logic [POS_W-1:0] d_ls_q, d_ls_d;
  logic             tick;

  // Next left edge for one paddle at a move tick.
  function automatic logic [POS_W-1:0] next_ls(
    input logic [POS_W-1:0] ls,
    input logic             key_l,
    input logic             key_r,
    input logic             auto_m,
    input logic [POS_W-1:0] bx
  );
    logic [EXT_W-1:0] ls_e;
    logic [EXT_W-1:0] c_e;
    logic [EXT_W-1:0] b_e;
    logic             go_l;
    logic             go_r;
    ls_e = EXT_W'(ls);
    c_e  = ls_e + EXT_W'(HALF_M1);
    b_e  = EXT_W'(bx);
    if (auto_m) begin
      go_r = b_e > (c_e + EXT_W'(DEADBAND));
      go_l = (b_e + EXT_W'(DEADBAND)) < c_e;
    end else begin
      go_l = key_l & ~key_r;
      go_r = key_r & ~key_l;
    end
    next_ls = ls;
    if (go_l) begin
      next_ls = (ls_e >= EXT_W'(STEP)) ? POS_W'(ls_e - EXT_W'(STEP)) : '0;
    end else if (go_r) begin
      next_ls = ((ls_e + EXT_W'(STEP)) <= EXT_W'(LS_MAX)) ?
                POS_W'(ls_e + EXT_W'(STEP)) : POS_W'(LS_MAX);
    end
    return next_ls;
  endfunction

  // Tick divider and position update.
  always_comb begin
    tick   = 1'b0;
    cnt_d  = cnt_q;
    u_ls_d = u_ls_q;
    d_ls_d = d_ls_q;
    if (!pause) begin
      tick  = (cnt_q == CNT_W'(CNT_TOP));
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
    if (tick) begin
      u_ls_d = next_ls(u_ls_q, key_ul, key_ur, mode_u, ball_x);
      d_ls_d = next_ls(d_ls_q, key_dl, key_dr, mode_d, ball_x);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      u_ls_q <= POS_W'(LS_RST);
      d_ls_q <= POS_W'(LS_RST);
    end else begin
      cnt_q  <= cnt_d;
      u_ls_q <= u_ls_d;
      d_ls_q <= d_ls_d;
    end
  end

  assign paddleU_ls  = u_ls_q;
  assign paddleD_ls  = d_ls_q;
  assign paddleU_pos = u_ls_q + POS_W'(HALF_M1);
  assign paddleD_pos = d_ls_q + POS_W'(HALF_M1);
  assign bound_u     = {u_ls_q == POS_W'(LS_MAX), u_ls_q == '0};
  assign bound_d     = {d_ls_q == POS_W'(LS_MAX), d_ls_q == '0};

endmodule
